// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for the five-stage core.
// Decides hold/bubble/flush for the pipeline registers, drives the EX-stage
// forwarding selects, freezes the pipe during data-memory waits and traps a
// memory timeout into a sticky error state.
// Optional feature macro: PIPE_CTRL_PERF_EN adds saturating performance
// counters stall_cnt, flush_cnt and wait_cnt.
module pipe_ctrl #(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_is_load,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             br_taken,
  input  logic             dm_req,
  input  logic             dm_ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_bubble,
  output logic             flush,
  output logic             exmem_hold,
  output logic             memwb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
`endif
);

  typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_t;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t     state, state_nxt;
  logic [7:0] wait_ctr;
  logic       dm_wait;
  logic       freeze;
  logic       load_use;
  logic       stall;

  // Operand source: MEM result beats WB data; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rs))
      return 2'b01;
    else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  // Saturating increment for the 8-bit wait counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  // Hazard detection, priority resolution (freeze > flush > stall) and next state.
  always_comb begin
    state_nxt    = state;
    dm_wait      = dm_req & ~dm_ready;
    freeze       = (state == ERR) | dm_wait;
    load_use     = ex_is_load & ex_regwrite & (ex_rd != 5'd0) &
                   ((id_use_rs1 & (id_rs1 == ex_rd)) |
                    (id_use_rs2 & (id_rs2 == ex_rd)));
    // A dependent instruction behind a taken branch is on the wrong path.
    stall        = load_use & ~freeze & ~br_taken;
    flush        = br_taken & ~freeze;
    pc_hold      = freeze | stall;
    ifid_hold    = freeze | stall;
    idex_bubble  = stall;
    exmem_hold   = freeze;
    memwb_bubble = freeze;
    fwd_a        = fwd_sel(ex_rs1);
    fwd_b        = fwd_sel(ex_rs2);
    mem_err      = (state == ERR);
    unique case (state)
      RUN:     if (dm_wait) state_nxt = MEMWAIT;
      // The counter holds the number of cycles already waited; ready in the
      // cycle it shows WAIT_MAX still completes normally.
      MEMWAIT: if (!dm_wait)                   state_nxt = RUN;
               else if (wait_ctr == WAIT_LIM)  state_nxt = ERR;
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  // State register and memory-wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_ctr <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_ctr <= dm_wait ? sat_inc8(wait_ctr) : 8'd0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Performance counters: stall cycles, flush cycles, freeze cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (stall)  stall_cnt <= sat_inc(stall_cnt);
      if (flush)  flush_cnt <= sat_inc(flush_cnt);
      if (freeze) wait_cnt  <= sat_inc(wait_cnt);
    end
  end
`endif

endmodule
